// File: rtl/fc_layer_seq.sv
// Sequencer for a combinational fully-connected layer array: serial load, multicycle settle, serial drain.
// Optional FC_SEQ_ARGMAX_EN adds argmax_idx/argmax_valid tracking of the drained results.
module fc_layer_seq #(
    parameter int WIDTH   = 8,
    parameter int IN      = 128,
    parameter int OUT     = 50,
    parameter int Z_WIDTH = 22,
    parameter int SETTLE  = 2,
    localparam int IDX_W  = (OUT > 1) ? $clog2(OUT) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic [IN*WIDTH-1:0]      x_bus,
    input  logic [OUT*Z_WIDTH-1:0]   z_bus,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [Z_WIDTH-1:0]       out_data,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_last,
    output logic                     busy
`ifdef FC_SEQ_ARGMAX_EN
    ,
    output logic [IDX_W-1:0]         argmax_idx,
    output logic                     argmax_valid
`endif
);
    localparam int WR_W  = $clog2(IN);
    localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [WR_W-1:0]  WR_LAST = WR_W'(IN - 1);
    localparam logic [IDX_W-1:0] RD_LAST = IDX_W'(OUT - 1);

    typedef enum logic [1:0] {S_LOAD, S_SETTLE, S_DRAIN} state_t;

    state_t           state;
    logic [WR_W-1:0]  wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [CNT_W-1:0] settle_cnt;

    // Gated by rst so upstream never sees a handshake while reset is asserted.
    assign in_ready = (state == S_LOAD) && !rst;
    assign out_data = z_bus[int'(rd_idx)*Z_WIDTH +: Z_WIDTH];
    assign out_idx  = rd_idx;
    assign out_last = out_valid && (rd_idx == RD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_LOAD;
            wr_idx     <= '0;
            rd_idx     <= '0;
            settle_cnt <= '0;
            x_bus      <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (in_valid) begin
                        x_bus[int'(wr_idx)*WIDTH +: WIDTH] <= in_data;
                        if (wr_idx == WR_LAST) begin
                            wr_idx <= '0;
                            busy   <= 1'b1;
                            if (SETTLE == 0) begin
                                state     <= S_DRAIN;
                                out_valid <= 1'b1;
                            end else begin
                                settle_cnt <= CNT_W'(SETTLE);
                                state      <= S_SETTLE;
                            end
                        end else begin
                            wr_idx <= wr_idx + 1'b1;
                        end
                    end
                end
                // Counter reaches zero one cycle before DRAIN, giving SETTLE+1 cycles of x_bus stability.
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state     <= S_DRAIN;
                        out_valid <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (rd_idx == RD_LAST) begin
                            rd_idx    <= '0;
                            state     <= S_LOAD;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

`ifdef FC_SEQ_ARGMAX_EN
    logic [Z_WIDTH-1:0] max_val;
    logic [IDX_W-1:0]   max_idx;
    logic               take;

    // Index 0 restarts tracking; strict > keeps the lowest index on ties.
    assign take = (rd_idx == '0) || (out_data > max_val);

    always_ff @(posedge clk) begin
        if (out_valid && out_ready && take) begin
            max_val <= out_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            max_idx      <= '0;
            argmax_idx   <= '0;
            argmax_valid <= 1'b0;
        end else begin
            argmax_valid <= 1'b0;
            if (out_valid && out_ready) begin
                if (take) begin
                    max_idx <= rd_idx;
                end
                if (out_last) begin
                    argmax_idx   <= take ? rd_idx : max_idx;
                    argmax_valid <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_fc_layer_seq.sv
// Scoreboard bench for fc_layer_seq: a main instance (IN=128, OUT=50, SETTLE=2) and a small one (IN=4, OUT=1, SETTLE=0).
module tb_fc_layer_seq;
    localparam int WIDTH = 8, IN = 128, OUT = 50, ZW = 22, SETTLE = 2;
    localparam int S_IN = 4, S_OUT = 1, S_SETTLE = 0;
    localparam int IDX_W = $clog2(OUT);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                  in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [WIDTH-1:0]      in_data;
    logic [IN*WIDTH-1:0]   x_bus;
    logic [OUT*ZW-1:0]     z_bus;
    logic [ZW-1:0]         out_data;
    logic [IDX_W-1:0]      out_idx;

    logic                  s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last, s_busy;
    logic [WIDTH-1:0]      s_in_data;
    logic [S_IN*WIDTH-1:0] s_x_bus;
    logic [S_OUT*ZW-1:0]   s_z_bus;
    logic [ZW-1:0]         s_out_data;
    logic [0:0]            s_out_idx;

    fc_layer_seq #(.WIDTH(WIDTH), .IN(IN), .OUT(OUT), .Z_WIDTH(ZW), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .x_bus(x_bus), .z_bus(z_bus), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .busy(busy));

    fc_layer_seq #(.WIDTH(WIDTH), .IN(S_IN), .OUT(S_OUT), .Z_WIDTH(ZW), .SETTLE(S_SETTLE)) sdut (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .x_bus(s_x_bus), .z_bus(s_z_bus), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .out_idx(s_out_idx), .out_last(s_out_last), .busy(s_busy));

    function automatic int wgt(int i, int j);
        return (i * 7 + j * 3) % 5;
    endfunction

    // Stand-in for the combinational layer array, driven from the DUT's registered activations.
    always_comb begin
        int acc;
        acc = 0;
        z_bus = '0;
        for (int j = 0; j < OUT; j++) begin
            acc = 0;
            for (int i = 0; i < IN; i++) acc += int'(x_bus[i*WIDTH +: WIDTH]) * wgt(i, j);
            z_bus[j*ZW +: ZW] = acc[ZW-1:0];
        end
    end

    always_comb begin
        int sacc;
        sacc = 5;
        for (int i = 0; i < S_IN; i++) sacc += int'(s_x_bus[i*WIDTH +: WIDTH]) * (i + 1);
        s_z_bus = sacc[ZW-1:0];
    end

    int act[IN];
    int s_act[S_IN];
    int checks = 0, errors = 0;
    int rmode = 0;

    typedef struct {
        logic [ZW-1:0] data;
        int            idx;
        logic          last;
    } exp_t;
    exp_t q[$];
    exp_t sq[$];

    function automatic logic [ZW-1:0] ref_z(int j);
        int s = 0;
        for (int i = 0; i < IN; i++) s += act[i] * wgt(i, j);
        return s[ZW-1:0];
    endfunction

    function automatic logic [ZW-1:0] ref_sz();
        int s = 5;
        for (int i = 0; i < S_IN; i++) s += s_act[i] * (i + 1);
        return s[ZW-1:0];
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Main monitor: pops on every handshake, and verifies outputs hold while stalled.
    logic [ZW-1:0]    prev_data;
    logic [IDX_W-1:0] prev_idx;
    bit               stalled = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            if (stalled) begin
                check("stall_data", 64'(out_data), 64'(prev_data));
                check("stall_idx", 64'(out_idx), 64'(prev_idx));
            end
            if (out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got idx %0d data %0d expected no beat", out_idx, out_data);
                end else begin
                    e = q.pop_front();
                    check("out_data", 64'(out_data), 64'(e.data));
                    check("out_idx", 64'(out_idx), 64'(e.idx));
                    check("out_last", 64'(out_last), 64'(e.last));
                end
                stalled = 0;
            end else begin
                stalled   = 1;
                prev_data = out_data;
                prev_idx  = out_idx;
            end
        end else begin
            stalled = 0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && s_out_valid && s_out_ready) begin
            if (sq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL s_unexpected_beat: got data %0d expected no beat", s_out_data);
            end else begin
                e = sq.pop_front();
                check("s_out_data", 64'(s_out_data), 64'(e.data));
                check("s_out_idx", 64'(s_out_idx), 64'(e.idx));
                check("s_out_last", 64'(s_out_last), 64'(e.last));
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1:       out_ready = ~out_ready;
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Entered and left at posedge+1; the beat is taken on the edge after in_ready is seen high.
    task automatic send_beat(input int v);
        int n = 0;
        in_valid = 1'b1;
        in_data  = 8'(v);
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 5000) begin
                $display("FAIL in_ready_timeout: got in_ready 0 expected 1 within 5000 cycles");
                $fatal(1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_main(input int pattern, input int gaps);
        logic [IN*WIDTH-1:0] xv;
        int first, low, n;
        for (int i = 0; i < IN; i++) act[i] = (pattern == 0) ? (i % 256) : int'($urandom_range(0, 255));
        for (int i = 0; i < IN; i++) begin
            if (gaps != 0 && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            send_beat(act[i]);
        end
        in_valid = 1'b0;
        for (int j = 0; j < OUT; j++) q.push_back('{ref_z(j), j, (j == OUT - 1)});
        for (int i = 0; i < IN; i++) xv[i*WIDTH +: WIDTH] = 8'(act[i]);
        @(negedge clk);
        checks++;
        if (x_bus !== xv) begin
            errors++;
            $display("FAIL x_bus: got %h expected %h", x_bus, xv);
        end
        first = -1;
        low   = 0;
        for (n = 0; n < 5000; n++) begin
            if (n > 0) @(negedge clk);
            if (first < 0 && out_valid) first = n;
            if (in_ready) break;
            low++;
        end
        check("drain_done", 64'(n < 5000), 64'd1);
        check("latency", 64'(first), 64'(SETTLE + 1));
        if (rmode == 0) check("in_ready_low", 64'(low), 64'(1 + SETTLE + OUT));
        check("q_empty", 64'(q.size()), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic load_small();
        int first, n;
        for (int i = 0; i < S_IN; i++) begin
            s_act[i] = int'($urandom_range(0, 255));
            s_in_valid = 1'b1;
            s_in_data  = 8'(s_act[i]);
            n = 0;
            forever begin
                @(negedge clk);
                if (s_in_ready) break;
                n++;
                if (n > 1000) begin
                    $display("FAIL s_in_ready_timeout: got 0 expected 1 within 1000 cycles");
                    $fatal(1);
                end
            end
            @(posedge clk);
            #1;
        end
        s_in_valid = 1'b0;
        sq.push_back('{ref_sz(), 0, 1'b1});
        first = -1;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (first < 0 && s_out_valid) first = n;
            if (s_in_ready) break;
        end
        check("s_latency", 64'(first), 64'd0);
        check("s_back_to_load", 64'(n), 64'd1);
        check("s_q_empty", 64'(sq.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        s_in_valid = 1'b0;
        s_in_data = '0;
        s_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_xbus_zero", 64'(x_bus == '0), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        rmode = 0;
        load_main(0, 0);
        rmode = 1;
        load_main(1, 0);
        rmode = 2;
        load_main(1, 1);

        rmode = 0;
        for (int i = 0; i < 60; i++) send_beat(int'($urandom_range(0, 255)));
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_ready_after", 64'(in_ready), 64'd1);
        check("mid_rst_xbus_zero", 64'(x_bus == '0), 64'd1);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        load_main(1, 0);

        for (int k = 0; k < 3; k++) load_small();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish before 2000000");
        $fatal(1);
    end
endmodule
